// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2 convolutional encoder, K = 3..6, sitting between UART RX and TX.
// Each accepted byte is encoded MSB-first over 8 cycles. Each 2-bit symbol is streamed out
// locally and also packed into two bytes, which are then handed to the UART transmitter.
// Ports:
//   clk, rst (sync, active-high)
//   data_in/data_valid       byte strobe from the receiver; dropped with an overrun pulse when busy
//   choose_constraint_length K select, latched at accept; illegal values fall back to K=3
//   clear_state              zeroes the encoder history while idle
//   tx_busy                  transmitter busy flag
//   encoded_bits/encoded_valid  per-bit symbol {g0 parity, g1 parity}
//   tx_data/tx_start         byte and one-cycle request to the transmitter
//   ready, overrun           idle indication and dropped-byte pulse
module conv_encoder_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic [2:0] choose_constraint_length,
   input  logic       clear_state,
   input  logic       tx_busy,
   output logic [1:0] encoded_bits,
   output logic       encoded_valid,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       ready,
   output logic       overrun
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ENC  = 3'd1;
   localparam logic [2:0] ST_TX0  = 3'd2;
   localparam logic [2:0] ST_G0   = 3'd3;  // guard cycle while tx_busy catches up
   localparam logic [2:0] ST_W0   = 3'd4;
   localparam logic [2:0] ST_TX1  = 3'd5;
   localparam logic [2:0] ST_G1   = 3'd6;
   localparam logic [2:0] ST_W1   = 3'd7;

   logic [2:0]  state_q, state_d;
   logic [4:0]  s_q, s_d;
   logic [7:0]  byte_q, byte_d;
   logic [1:0]  ksel_q, ksel_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] pack_q, pack_d;
   logic [1:0]  sym_q, sym_d;
   logic        sym_vld_q, sym_vld_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        overrun_q, overrun_d;

   logic        in_bit;
   logic [5:0]  win;
   logic [5:0]  g0, g1;
   logic [1:0]  sym;
   logic [1:0]  ksel_in;

   // Bit 7-i is encoded in cycle i.
   assign in_bit = byte_q[3'd7 - cnt_q];

   // Window is left-aligned: bit 5 = current input, bit 4 = s[0], and so on.
   // The polynomials are left-aligned to match, so history bits above K-2 hit zero taps.
   assign win = {in_bit, s_q[0], s_q[1], s_q[2], s_q[3], s_q[4]};

   always_comb begin
      g0 = 6'b111000;
      g1 = 6'b101000;
      case (ksel_q)
         2'd1:    begin g0 = 6'b111100; g1 = 6'b110100; end   // 17 / 15
         2'd2:    begin g0 = 6'b100110; g1 = 6'b111010; end   // 23 / 35
         2'd3:    begin g0 = 6'b101011; g1 = 6'b111101; end   // 53 / 75
         default: begin g0 = 6'b111000; g1 = 6'b101000; end   // 7 / 5
      endcase
   end

   assign sym = {^(g0 & win), ^(g1 & win)};

   always_comb begin
      case (choose_constraint_length)
         3'd4:    ksel_in = 2'd1;
         3'd5:    ksel_in = 2'd2;
         3'd6:    ksel_in = 2'd3;
         default: ksel_in = 2'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      byte_d     = byte_q;
      ksel_d     = ksel_q;
      cnt_d      = cnt_q;
      pack_d     = pack_q;
      sym_d      = sym_q;
      sym_vld_d  = 1'b0;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      overrun_d  = data_valid && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            // Clear takes effect before a same-cycle accept: the byte encodes from zero.
            if (clear_state) s_d = 5'd0;
            if (data_valid) begin
               byte_d  = data_in;
               ksel_d  = ksel_in;
               cnt_d   = 3'd0;
               state_d = ST_ENC;
            end
         end
         ST_ENC: begin
            sym_d     = sym;
            sym_vld_d = 1'b1;
            pack_d[{~cnt_q, 1'b0} +: 2] = sym;
            s_d       = {s_q[3:0], in_bit};
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_TX0;
         end
         ST_TX0: begin
            if (!tx_busy) begin
               tx_data_d  = pack_q[15:8];
               tx_start_d = 1'b1;
               state_d    = ST_G0;
            end
         end
         ST_G0: state_d = ST_W0;
         ST_W0: if (!tx_busy) state_d = ST_TX1;
         ST_TX1: begin
            if (!tx_busy) begin
               tx_data_d  = pack_q[7:0];
               tx_start_d = 1'b1;
               state_d    = ST_G1;
            end
         end
         ST_G1: state_d = ST_W1;
         ST_W1: if (!tx_busy) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         s_q        <= 5'd0;
         byte_q     <= 8'd0;
         ksel_q     <= 2'd0;
         cnt_q      <= 3'd0;
         pack_q     <= 16'd0;
         sym_q      <= 2'd0;
         sym_vld_q  <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         byte_q     <= byte_d;
         ksel_q     <= ksel_d;
         cnt_q      <= cnt_d;
         pack_q     <= pack_d;
         sym_q      <= sym_d;
         sym_vld_q  <= sym_vld_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overrun_q  <= overrun_d;
      end
   end

   assign encoded_bits  = sym_q;
   assign encoded_valid = sym_vld_q;
   assign tx_data       = tx_data_q;
   assign tx_start      = tx_start_q;
   assign overrun       = overrun_q;
   assign ready         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Testbench for conv_encoder_tx: directed and random bytes checked against a bit-level
// reference encoder, with a simple transmitter model providing tx_busy.
module tb_conv_encoder_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'd0;
   logic       data_valid = 1'b0;
   logic [2:0] choose_constraint_length = 3'd3;
   logic       clear_state = 1'b0;
   logic       tx_busy = 1'b0;
   logic [1:0] encoded_bits;
   logic       encoded_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ready;
   logic       overrun;

   conv_encoder_tx dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .choose_constraint_length(choose_constraint_length), .clear_state(clear_state),
      .tx_busy(tx_busy), .encoded_bits(encoded_bits), .encoded_valid(encoded_valid),
      .tx_data(tx_data), .tx_start(tx_start), .ready(ready), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int pcyc = 0;
   always @(posedge clk) pcyc <= pcyc + 1;

   logic [1:0] sym_q[$];
   logic [7:0] txq[$];
   int         stq[$];
   int         ovr_cnt = 0, stab_err = 0, width_err = 0;
   logic       prev_start = 1'b0;
   logic [7:0] last_tx;
   bit         rst_guard = 1'b1;
   bit         busy_force = 1'b0;
   int         busy_len = 0, busy_left = 0;

   // Monitor and transmitter model: busy for busy_len cycles after each tx_start.
   always @(negedge clk) begin
      if (encoded_valid) sym_q.push_back(encoded_bits);
      if (overrun) ovr_cnt++;
      if (tx_start) begin
         txq.push_back(tx_data);
         stq.push_back(pcyc);
         busy_left = busy_len;
      end
      if (tx_start && prev_start) width_err++;
      if (!tx_start && !rst_guard && tx_data !== last_tx) stab_err++;
      prev_start = tx_start;
      last_tx    = tx_data;
      tx_busy    = busy_force || (busy_left > 0);
      if (busy_left > 0) busy_left--;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic mhist[$];   // past input bits, most recent first

   task automatic mclear();
      mhist = {};
      for (int i = 0; i < 5; i++) mhist.push_back(1'b0);
   endtask

   function automatic int gpoly(input int k, input int which);
      case (k)
         4:       return which == 0 ? 'o17 : 'o15;
         5:       return which == 0 ? 'o23 : 'o35;
         6:       return which == 0 ? 'o53 : 'o75;
         default: return which == 0 ? 'o7  : 'o5;
      endcase
   endfunction

   task automatic model_byte(input logic [7:0] b, input int kraw, output logic [15:0] pk);
      int k;
      int g0, g1;
      k  = (kraw >= 3 && kraw <= 6) ? kraw : 3;
      g0 = gpoly(k, 0);
      g1 = gpoly(k, 1);
      pk = 16'd0;
      for (int i = 0; i < 8; i++) begin
         logic bitv, w, p0, p1;
         bitv = b[7-i];
         p0 = 1'b0;
         p1 = 1'b0;
         for (int j = 0; j < k; j++) begin
            w  = (j == 0) ? bitv : mhist[j-1];
            p0 = p0 ^ (g0[k-1-j] & w);
            p1 = p1 ^ (g1[k-1-j] & w);
         end
         pk[15-2*i] = p0;
         pk[14-2*i] = p1;
         mhist.push_front(bitv);
         void'(mhist.pop_back());
      end
   endtask

   // Send one byte and check its symbols and TX bytes. hold>0 forces tx_busy high for that
   // many cycles after the accept; ovr injects a 0x55 strobe during encoding.
   task automatic run_byte(input logic [7:0] b, input int k, input bit clr, input bit ovr,
                           input int hold, input string tag);
      logic [15:0] exp_pk, got;
      int s0, t0, o0, acc, n;
      if (clr) mclear();
      model_byte(b, k, exp_pk);
      s0 = sym_q.size();
      t0 = txq.size();
      o0 = ovr_cnt;
      if (hold > 0) busy_force = 1'b1;
      data_in = b;
      data_valid = 1'b1;
      choose_constraint_length = 3'(k);
      clear_state = clr;
      acc = pcyc + 1;
      @(negedge clk);
      data_valid = 1'b0;
      clear_state = 1'b0;
      choose_constraint_length = 3'($urandom_range(0, 7));
      if (ovr) begin
         repeat (3) @(negedge clk);
         data_in = 8'h55;
         data_valid = 1'b1;
         @(negedge clk);
         data_valid = 1'b0;
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, "_no_start_while_busy"}, txq.size(), t0);
         busy_force = 1'b0;
      end
      n = 0;
      while (!ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, ready, 1);
      check({tag, "_nsym"}, sym_q.size() - s0, 8);
      if (sym_q.size() - s0 == 8) begin
         got = 16'd0;
         for (int i = 0; i < 8; i++) got[15-2*i -: 2] = sym_q[s0+i];
         check({tag, "_symbols"}, got, exp_pk);
      end
      check({tag, "_ntx"}, txq.size() - t0, 2);
      if (txq.size() - t0 == 2) begin
         check({tag, "_tx0"}, txq[t0], exp_pk[15:8]);
         check({tag, "_tx1"}, txq[t0+1], exp_pk[7:0]);
         check({tag, "_tx0_latency"}, (stq[t0] - acc) >= 9, 1);
         check({tag, "_tx1_gap"}, (stq[t0+1] - stq[t0]) >= busy_len + 2, 1);
      end
      if (ovr) check({tag, "_overrun_pulses"}, ovr_cnt - o0, 1);
   endtask

   task automatic check_last_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1);
      check({tag, "_ntx_total"}, txq.size() >= 2, 1);
      if (txq.size() >= 2) begin
         check({tag, "_byte0"}, txq[txq.size()-2], b0);
         check({tag, "_byte1"}, txq[txq.size()-1], b1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      mclear();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_encoded_valid", encoded_valid, 0);
      check("rst_encoded_bits", encoded_bits, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      @(negedge clk);
      rst_guard = 1'b0;

      // K=3 single byte from zero state.
      run_byte(8'h80, 3, 1'b0, 1'b0, 0, "k3_80");
      check_last_tx("k3_80_const", 8'hEC, 8'h00);

      // State carries across bytes.
      run_byte(8'h01, 3, 1'b0, 1'b0, 0, "carry_01");
      check_last_tx("carry_01_const", 8'h00, 8'h03);
      run_byte(8'h00, 3, 1'b0, 1'b0, 0, "carry_00");
      check_last_tx("carry_00_const", 8'hB0, 8'h00);

      // Same pair with a standalone clear pulse in between.
      run_byte(8'h01, 3, 1'b0, 1'b0, 0, "clr_01");
      clear_state = 1'b1;
      @(negedge clk);
      clear_state = 1'b0;
      mclear();
      run_byte(8'h00, 3, 1'b0, 1'b0, 0, "clr_00");
      check_last_tx("clr_00_const", 8'h00, 8'h00);

      // Illegal K falls back to 3; other K values from zero state.
      run_byte(8'h80, 7, 1'b1, 1'b0, 0, "k7_80");
      check_last_tx("k7_80_const", 8'hEC, 8'h00);
      run_byte(8'h80, 4, 1'b1, 1'b0, 0, "k4_80");
      run_byte(8'hA7, 5, 1'b0, 1'b0, 0, "k5_a7");
      run_byte(8'h3C, 6, 1'b0, 1'b0, 0, "k6_3c");

      // Handshake: busy held high for 40 cycles, then a slow transmitter.
      busy_len = 5;
      run_byte(8'h96, 3, 1'b0, 1'b0, 40, "busy");

      // Overrun during encode.
      busy_len = 2;
      run_byte(8'h80, 3, 1'b1, 1'b1, 0, "ovr");
      check_last_tx("ovr_const", 8'hEC, 8'h00);

      // Random bytes, K (including illegal), clears and transmitter speed.
      for (int i = 0; i < 24; i++) begin
         busy_len = $urandom_range(0, 6);
         run_byte(8'($urandom_range(0, 255)), $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0), 1'b0, 0, $sformatf("rnd%0d", i));
      end

      // Reset in encode cycle 4.
      busy_len = 0;
      rst_guard = 1'b1;
      data_in = 8'hFF;
      choose_constraint_length = 3'd5;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", ready, 1);
      check("midrst_encoded_valid", encoded_valid, 0);
      check("midrst_encoded_bits", encoded_bits, 0);
      check("midrst_tx_start", tx_start, 0);
      check("midrst_tx_data", tx_data, 0);
      check("midrst_overrun", overrun, 0);
      t0 = txq.size();
      repeat (12) @(negedge clk);
      check("midrst_no_tx", txq.size(), t0);
      rst_guard = 1'b0;
      mclear();
      run_byte(8'h80, 3, 1'b0, 1'b0, 0, "after_rst");
      check_last_tx("after_rst_const", 8'hEC, 8'h00);

      check("tx_data_stable", stab_err, 0);
      check("tx_start_one_cycle", width_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
